// File: rtl/cgra_run_sequencer.sv
// rtl/cgra_run_sequencer.sv - init/settle/run phase sequencer for one host-issued CGRA job
// Optional feature macro: RUN_CYC_CNT_EN (adds run_cnt output counting run cycles)
module cgra_run_sequencer #(
    parameter int H_C_W         = 32,
    parameter int EX_W          = 64,
    parameter int CNT_W         = 16,
    parameter int INIT_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] run_cycles_i,
    input  logic [H_C_W-1:0] host_controller_i,
    input  logic [EX_W-1:0]  ex_bus_i,
    input  logic             abort_i,
    output logic             init,
    output logic             run,
    output logic [H_C_W-1:0] host_controller,
    output logic [EX_W-1:0]  ex_bus,
    output logic             busy,
    output logic             done
`ifdef RUN_CYC_CNT_EN
    ,
    output logic [CNT_W-1:0] run_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] INIT_LOAD   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] run_len;
    logic             accept;

    assign accept = (state == S_IDLE) && start_i;

    // Phase counters hold (remaining cycles - 1), so a phase ends when cnt reaches 0
    // and run_cycles_i of all-ones never needs a wider value.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (run_cycles_i != '0) begin
                        state_nxt = S_INIT;
                        cnt_nxt   = INIT_LOAD;
                    end else begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                    end
                end
            end
            S_INIT: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_nxt = S_SETTLE;
                        cnt_nxt   = SETTLE_LOAD;
                    end else begin
                        state_nxt = S_RUN;
                        cnt_nxt   = run_len - CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = run_len - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status strobes are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            run_len         <= '0;
            host_controller <= '0;
            ex_bus          <= '0;
            init            <= 1'b0;
            run             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                run_len         <= run_cycles_i;
                host_controller <= host_controller_i;
                ex_bus          <= ex_bus_i;
            end
            init <= (state_nxt == S_INIT);
            run  <= (state_nxt == S_RUN);
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);
        end
    end

`ifdef RUN_CYC_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt <= '0;
        end else if (accept) begin
            run_cnt <= '0;
        end else if (run && (run_cnt != '1)) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cgra_run_sequencer.sv
// tb/tb_cgra_run_sequencer.sv - self-checking bench for cgra_run_sequencer with a timeline reference model
module tb_cgra_run_sequencer;

    localparam int H_C_W = 32;
    localparam int EX_W  = 64;
    localparam int CNT_W = 16;
    localparam int IC    = 2;
    localparam int SC    = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] run_cycles_i;
    logic [H_C_W-1:0] host_controller_i;
    logic [EX_W-1:0]  ex_bus_i;
    logic             abort_i;
    logic             init;
    logic             run;
    logic [H_C_W-1:0] host_controller;
    logic [EX_W-1:0]  ex_bus;
    logic             busy;
    logic             done;
`ifdef RUN_CYC_CNT_EN
    logic [CNT_W-1:0] run_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a job is a timeline of relative cycles 1..job_end after acceptance.
    bit           m_act = 0;
    int           m_rel = 0;
    int           m_n   = 0;
    logic [31:0]  m_hc  = '0;
    logic [63:0]  m_ex  = '0;
    int           m_rc  = 0;

    cgra_run_sequencer #(
        .H_C_W(H_C_W), .EX_W(EX_W), .CNT_W(CNT_W),
        .INIT_CYCLES(IC), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .run_cycles_i(run_cycles_i),
        .host_controller_i(host_controller_i), .ex_bus_i(ex_bus_i), .abort_i(abort_i),
        .init(init), .run(run), .host_controller(host_controller), .ex_bus(ex_bus),
        .busy(busy), .done(done)
`ifdef RUN_CYC_CNT_EN
        , .run_cnt(run_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int job_end();
        return (m_n == 0) ? 1 : IC + SC + m_n + 1;
    endfunction
    function automatic bit e_init();
        return m_act && m_n != 0 && m_rel >= 1 && m_rel <= IC;
    endfunction
    function automatic bit e_run();
        return m_act && m_n != 0 && m_rel > IC + SC && m_rel <= IC + SC + m_n;
    endfunction
    function automatic bit e_done();
        return m_act && m_rel == job_end();
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit was_run;
        was_run = e_run();
        if (rst) begin
            m_act = 0; m_rel = 0; m_n = 0; m_hc = '0; m_ex = '0; m_rc = 0;
        end else begin
            if (!m_act) begin
                if (start_i) begin
                    m_act = 1; m_rel = 1; m_n = int'(run_cycles_i);
                    m_hc = host_controller_i; m_ex = ex_bus_i; m_rc = 0;
                end
            end else if (m_rel == job_end() || abort_i) begin
                m_act = 0; m_rel = 0;
            end else begin
                m_rel++;
            end
            if (was_run && m_rc < (1 << CNT_W) - 1) m_rc++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("init", init, e_init());
        check("run", run, e_run());
        check("done", done, e_done());
        check("busy", busy, m_act);
        check("host_controller", host_controller, m_hc);
        check("ex_bus", ex_bus, m_ex);
`ifdef RUN_CYC_CNT_EN
        check("run_cnt", run_cnt, m_rc);
`endif
    endtask

    task automatic idle_inputs();
        rst = 0; start_i = 0; abort_i = 0;
    endtask

    task automatic issue(input int n, input logic [31:0] hc, input logic [63:0] ex);
        start_i = 1; run_cycles_i = CNT_W'(n); host_controller_i = hc; ex_bus_i = ex;
        tick();
        start_i = 0;
    endtask

    initial begin
        rst = 1; start_i = 0; abort_i = 0; run_cycles_i = '0;
        host_controller_i = '0; ex_bus_i = '0;
        tick();
        tick();
        idle_inputs();
        tick();

        // Basic job: init 1-2, settle 3, run 4-6, done 7
        issue(3, 32'hA5A5_0001, 64'h1234);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick();
            check("basic_done_at7", done, k == 7);
            check("basic_run_4to6", run, k >= 4 && k <= 6);
            if (k == 1) host_controller_i = 32'hDEAD_BEEF;
        end
        check("basic_hc_held", host_controller, 32'hA5A5_0001);

        // Zero length job
        tick();
        issue(0, 32'h0000_0002, 64'h55);
        check("zero_done", done, 1'b1);
        check("zero_init", init, 1'b0);
        tick();
        check("zero_busy_clear", busy, 1'b0);

        // Start held continuously: done at 5, next init at 7
        start_i = 1; run_cycles_i = 1; host_controller_i = 32'h1111_0003; ex_bus_i = 64'hABC;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 2) host_controller_i = 32'h2222_0004;
            if (k == 5) check("held_done_at5", done, 1'b1);
            if (k == 7) check("held_init_at7", init, 1'b1);
        end
        idle_inputs();
        for (int k = 0; k < 8; k++) tick();

        // Abort in run: abort at cycle 5 of a 10-cycle job
        issue(10, 32'h3333_0005, 64'h77);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) abort_i = 1;
            tick();
            abort_i = 0;
        end
        check("abort_busy", busy, 1'b0);
        check("abort_hc", host_controller, 32'h3333_0005);

        // Reset mid-run, then a normal start
        issue(6, 32'h4444_0006, 64'h99);
        for (int k = 1; k <= 5; k++) tick();
        rst = 1;
        tick();
        rst = 0;
        check("rst_hc", host_controller, 32'h0);
        issue(2, 32'h5555_0007, 64'h1);
        for (int k = 0; k < 8; k++) tick();

        // Count job of length 5, then abort after 2 run cycles
        issue(5, 32'h6, 64'h6);
        for (int k = 0; k < 9; k++) tick();
        issue(5, 32'h7, 64'h7);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) abort_i = 1;
            tick();
            abort_i = 0;
        end
        for (int k = 0; k < 3; k++) tick();

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst               = ($urandom_range(0, 99) == 0);
            start_i           = ($urandom_range(0, 3) == 0);
            abort_i           = ($urandom_range(0, 24) == 0);
            run_cycles_i      = CNT_W'($urandom_range(0, 7));
            host_controller_i = $urandom;
            ex_bus_i          = {$urandom, $urandom};
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
